w5300_access_gate: RTL and testbench
====================================

# w5300_access_gate

Host-side counterpart to the W5300 reset generator: monitors the chip's active-low reset line and enforces the post-reset PLL lock delay. Once the chip is usable, it runs host read and write requests as timed CS/RD/WR strobe cycles. It sits between the QL bus decode logic and the W5300 control pins. It guarantees that the host bus is never stalled indefinitely and that the chip is never accessed while in reset or still locking.

## Interface
- LOCK_CYCLES, 200000: clk cycles from reset release until accesses are allowed (10 ms at 20 MHz).
- CNT_W, 18: lock counter width; must satisfy 2^CNT_W ≥ LOCK_CYCLES.
- STROBE_CYCLES, 3: cycles that CS plus RD or WR are held low per access; minimum 1.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- w5300_resetl  in  1  W5300 reset line as driven to the chip; asynchronous to clk, synchronised internally.
- host_req  in  1  access request, level; held until host_ack is seen.
- host_rnw  in  1  1 = read, 0 = write; sampled with host_req in IDLE.
- host_ack  out  1  access complete; held until host_req drops.
- host_err  out  1  valid with host_ack; 1 = access refused or aborted.
- ready  out  1  chip out of reset and lock delay expired.
- w5300_csl, w5300_rdl, w5300_wrl  out  1 each  active-low chip strobes.

## Operation
- w5300_resetl passes through a 2-flop synchroniser; rl_s denotes the synchronised value.
- States: RESET, LOCK, IDLE, STROBE, ACK.
- rst=1: state RESET, counters 0. Outputs: ready=0, host_ack=0, host_err=0, all strobes=1. All outputs are registered.
- From any state, rl_s=0 moves the next state to RESET. This overrides every transition below.
- RESET → LOCK when rl_s=1; lock counter cleared to 0.
- LOCK: counter increments each cycle. At count == LOCK_CYCLES-1 → IDLE. ready=1 from the first IDLE cycle.
- RESET or LOCK with host_req=1 and host_ack=0:
  - host_ack=1 and host_err=1 the next cycle; no strobes driven.
  - ack stays high until host_req=0.
  - This is a refusal; the state stays RESET/LOCK and counting continues.
- IDLE with host_req=1:
  - Latch host_rnw; → STROBE.
  - csl=0 and rdl=0 (read) or wrl=0 (write) from the next cycle.
  - Strobe counter cleared.
- STROBE: strobes held for exactly STROBE_CYCLES cycles, then → ACK. In the ACK cycle all strobes=1, host_ack=1 and host_err=0.
- ACK: hold host_ack until host_req=0, then → IDLE with host_ack=0. A new request cannot start in that same cycle.
- Abort: rl_s falls during STROBE or ACK.
  - Next cycle: strobes=1, ready=0, state RESET.
  - If ack was not yet given, host_ack=1 and host_err=1 until host_req drops.
- host_rnw changes after latching are ignored.

## Timing
- Reset release to ready:
  - Synchroniser delay is 2 cycles, plus 1 cycle RESET→LOCK, plus LOCK_CYCLES.
  - ready rises LOCK_CYCLES+3 cycles after the first clk edge that samples w5300_resetl=1.
- Access latency: host_req sampled high in IDLE at cycle N.
  - Strobes are low in cycles N+1 through N+STROBE_CYCLES.
  - host_ack is high from N+STROBE_CYCLES+1.
- Refusal latency: host_ack=1 one cycle after host_req is sampled high.
- Reset mid-access: strobes return high no more than 3 cycles after w5300_resetl falls (2 synchroniser + 1).
- rd and wr are never both low. csl is low exactly when either rd or wr is low.

## Structure
- w5300_pkg:
  - state enum (RESET, LOCK, IDLE, STROBE, ACK);
  - default LOCK_CYCLES and STROBE_CYCLES constants.
- Sub-module w5300_sync2: generic 2-flop synchroniser (clk, rst, d, q). rst drives q to 0, so ready is held off until the line is sampled.
- Strobe counter width is $clog2(STROBE_CYCLES+1).

## Test plan
Bench parameters: LOCK_CYCLES=8, STROBE_CYCLES=3.
- Power-up: rst high 4 cycles with w5300_resetl=0, then release. Expect strobes=1, ready=0 throughout. Raise resetl at cycle 10; expect ready=1 at cycle 21.
- Read: host_req=1, host_rnw=1 in IDLE at cycle N. Expect csl=rdl=0 for N+1..N+3 with wrl=1 throughout; host_ack=1 and host_err=0 at N+4. Drop req; expect ack=0 next cycle.
- Write, back-to-back: hold host_req through ack, drop it for 1 cycle, reassert. Expect wrl low for 3 cycles each time, separated by at least one IDLE cycle with strobes high.
- Early request: host_req=1 at LOCK count 3. Expect host_ack=1 and host_err=1 one cycle later with no strobe activity; ready still rises on schedule.
- Abort: w5300_resetl falls at the second STROBE cycle. Expect strobes high within 3 cycles and host_ack=1 with host_err=1. Releasing resetl restarts the full lock count.
- rst mid-ACK: rst=1 while host_ack=1. Expect all outputs at reset values the next cycle and state RESET.

Source files
------------

// File: rtl/w5300_pkg.sv
// Shared state encoding and default timing constants for the W5300 host access gate.
package w5300_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_LOCK   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_STROBE = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam int unsigned DEF_LOCK_CYCLES   = 200000;
    localparam int unsigned DEF_CNT_W         = 18;
    localparam int unsigned DEF_STROBE_CYCLES = 3;

endpackage

// File: rtl/w5300_sync2.sv
// Two-flop synchroniser; reset forces the output low so downstream logic
// treats an unsampled line as asserted reset.
module w5300_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w5300_access_gate.sv
// Gates host accesses to the W5300: waits out chip reset and PLL lock, then runs
// timed CS/RD/WR strobe cycles and always answers the host with ack (ok or error).
module w5300_access_gate
    import w5300_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic w5300_resetl,
    input  logic host_req,
    input  logic host_rnw,
    output logic host_ack,
    output logic host_err,
    output logic ready,
    output logic w5300_csl,
    output logic w5300_rdl,
    output logic w5300_wrl
);

    localparam int unsigned SCNT_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [SCNT_W-1:0] STROBE_LAST = SCNT_W'(STROBE_CYCLES - 1);

    state_t              state;
    logic                rl_s;
    logic [CNT_W-1:0]    lock_cnt;
    logic [SCNT_W-1:0]   strb_cnt;
    logic                ref_ack_c;
    logic                ref_err_c;

    w5300_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (w5300_resetl),
        .q   (rl_s)
    );

    // Handshake while the chip is unusable: refuse new requests, release on req drop.
    always_comb begin
        ref_ack_c = host_ack;
        ref_err_c = host_err;
        if (host_req && !host_ack) begin
            ref_ack_c = 1'b1;
            ref_err_c = 1'b1;
        end else if (host_ack && !host_req) begin
            ref_ack_c = 1'b0;
            ref_err_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET;
            lock_cnt  <= '0;
            strb_cnt  <= '0;
            host_ack  <= 1'b0;
            host_err  <= 1'b0;
            ready     <= 1'b0;
            w5300_csl <= 1'b1;
            w5300_rdl <= 1'b1;
            w5300_wrl <= 1'b1;
        end else if (!rl_s) begin
            // Chip in reset: abandon whatever was in flight.
            state     <= ST_RESET;
            ready     <= 1'b0;
            w5300_csl <= 1'b1;
            w5300_rdl <= 1'b1;
            w5300_wrl <= 1'b1;
            host_ack  <= ref_ack_c;
            host_err  <= ref_err_c;
        end else begin
            unique case (state)
                ST_RESET: begin
                    state    <= ST_LOCK;
                    lock_cnt <= '0;
                    host_ack <= ref_ack_c;
                    host_err <= ref_err_c;
                end
                ST_LOCK: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                    host_ack <= ref_ack_c;
                    host_err <= ref_err_c;
                end
                ST_IDLE: begin
                    // A refusal ack carried over from LOCK must be released first.
                    if (host_ack) begin
                        if (!host_req) begin
                            host_ack <= 1'b0;
                            host_err <= 1'b0;
                        end
                    end else if (host_req) begin
                        state     <= ST_STROBE;
                        strb_cnt  <= '0;
                        w5300_csl <= 1'b0;
                        w5300_rdl <= ~host_rnw;
                        w5300_wrl <= host_rnw;
                    end
                end
                ST_STROBE: begin
                    if (strb_cnt == STROBE_LAST) begin
                        state     <= ST_ACK;
                        w5300_csl <= 1'b1;
                        w5300_rdl <= 1'b1;
                        w5300_wrl <= 1'b1;
                        host_ack  <= 1'b1;
                        host_err  <= 1'b0;
                    end else begin
                        strb_cnt <= strb_cnt + SCNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (!host_req) begin
                        state    <= ST_IDLE;
                        host_ack <= 1'b0;
                        host_err <= 1'b0;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_access_gate.sv
// Scoreboard bench for w5300_access_gate: the driver queues the expected outcome of
// each host transaction, a negedge monitor checks the pins and pops on every ack.
module tb_w5300_access_gate;

    localparam int unsigned L = 8;
    localparam int unsigned S = 3;

    logic clk = 1'b0;
    logic rst, resetl, req, rnw;
    logic ack, err, ready, csl, rdl, wrl;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int exp_ready_cyc = -1;

    // len < 0: aborted access, strobe length only bounded; ack_cyc < 0: latency unchecked
    typedef struct {
        bit err;
        bit rnw;
        int len;
        int ack_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   ack_q = 1'b0;
    bit   rdy_q = 1'b0;
    int   n_cs = 0, n_rd = 0, n_wr = 0;

    w5300_access_gate #(
        .LOCK_CYCLES   (L),
        .CNT_W         (4),
        .STROBE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w5300_resetl (resetl),
        .host_req     (req),
        .host_rnw     (rnw),
        .host_ack     (ack),
        .host_err     (err),
        .ready        (ready),
        .w5300_csl    (csl),
        .w5300_rdl    (rdl),
        .w5300_wrl    (wrl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    // Pin monitor and scoreboard
    always @(negedge clk) begin
        tests++;
        if (!(rdl | wrl) || (csl !== (rdl & wrl))) begin
            fails++;
            $display("FAIL strobe_rules cyc=%0d: csl=%b rdl=%b wrl=%b, required csl=rdl&wrl and not both low",
                     cyc, csl, rdl, wrl);
        end
        if (!csl) n_cs++;
        if (!rdl) n_rd++;
        if (!wrl) n_wr++;

        if (ready && !rdy_q) begin
            tests++;
            if (cyc != exp_ready_cyc) begin
                fails++;
                $display("FAIL ready_rise: rose at cyc %0d, required cyc %0d", cyc, exp_ready_cyc);
            end
            exp_ready_cyc = -1;
        end

        if (ack && !ack_q) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: ack at cyc %0d, required no ack", cyc);
            end else begin
                e = sb.pop_front();
                if (err !== e.err) begin
                    fails++;
                    $display("FAIL ack_err cyc=%0d: got %b, required %b", cyc, err, e.err);
                end
                if (e.ack_cyc >= 0) begin
                    tests++;
                    if (cyc != e.ack_cyc) begin
                        fails++;
                        $display("FAIL ack_latency: ack at cyc %0d, required cyc %0d", cyc, e.ack_cyc);
                    end
                end
                tests++;
                if (e.len >= 0) begin
                    if (n_cs != e.len || (e.rnw ? n_rd : n_wr) != e.len || (e.rnw ? n_wr : n_rd) != 0) begin
                        fails++;
                        $display("FAIL strobe_len cyc=%0d: cs=%0d rd=%0d wr=%0d, required cs=%0d on %s only",
                                 cyc, n_cs, n_rd, n_wr, e.len, e.rnw ? "rd" : "wr");
                    end
                end else if (n_cs > int'(S)) begin
                    fails++;
                    $display("FAIL abort_strobe_len cyc=%0d: cs=%0d, required at most %0d", cyc, n_cs, S);
                end
            end
            n_cs = 0;
            n_rd = 0;
            n_wr = 0;
        end
        ack_q = ack;
        rdy_q = ready;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d, required %0d", name, cyc, got, want);
        end
    endtask

    task automatic check_idle_pins(input string name, input int want_ready);
        check({name, "_csl"}, int'(csl), 1);
        check({name, "_rdl"}, int'(rdl), 1);
        check({name, "_wrl"}, int'(wrl), 1);
        check({name, "_ready"}, int'(ready), want_ready);
    endtask

    task automatic wait_ack(input int limit);
        int n;
        n = 0;
        do begin
            tick();
            rnw = 1'($urandom_range(0, 1));
            n++;
        end while (!ack && n < limit);
        if (!ack) check("ack_timeout", 0, 1);
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    // One host transaction: queue the expectation, request, hold, release.
    task automatic run_access(input bit r, input bit refuse, input int hold, input int gap);
        exp_t x;
        x.err     = refuse;
        x.rnw     = r;
        x.len     = refuse ? 0 : int'(S);
        x.ack_cyc = cyc + (refuse ? 1 : int'(S) + 1);
        sb.push_back(x);
        req = 1'b1;
        rnw = r;
        wait_ack(64);
        repeat (hold) begin
            tick();
            rnw = 1'($urandom_range(0, 1));
        end
        req = 1'b0;
        tick();
        check("ack_release", int'(ack), 0);
        check("err_release", int'(err), 0);
        repeat (gap) tick();
    endtask

    initial begin
        exp_t x;
        int   off;
        rst    = 1'b1;
        resetl = 1'b0;
        req    = 1'b0;
        rnw    = 1'b0;

        // Power-up: controller reset with chip reset asserted
        repeat (4) begin
            tick();
            check_idle_pins("rst_state", 0);
            check("rst_ack", int'(ack), 0);
            check("rst_err", int'(err), 0);
        end
        rst = 1'b0;
        while (cyc < 10) begin
            tick();
            check_idle_pins("chip_reset", 0);
        end
        resetl        = 1'b1;
        exp_ready_cyc = cyc + int'(L) + 3;

        // Early request during the lock count is refused
        repeat (5) tick();
        check("lock_not_ready", int'(ready), 0);
        run_access(1'b1, 1'b1, 0, 0);
        wait_ready(64);
        tick();

        // Directed read, then back-to-back writes with a one-cycle drop
        run_access(1'b1, 1'b0, 0, 1);
        run_access(1'b0, 1'b0, 1, 0);
        run_access(1'b0, 1'b0, 0, 0);

        // Randomized accesses
        for (int i = 0; i < 16; i++) begin
            run_access(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Abort: chip reset falls while strobes are active
        off       = int'($urandom_range(0, 1));
        x.err     = 1'b1;
        x.rnw     = 1'b1;
        x.len     = -1;
        x.ack_cyc = -1;
        sb.push_back(x);
        req = 1'b1;
        rnw = 1'b1;
        repeat (off) tick();
        resetl = 1'b0;
        repeat (3) tick();
        check_idle_pins("abort", 0);
        check("abort_ack", int'(ack), 1);
        check("abort_err", int'(err), 1);
        req = 1'b0;
        tick();
        check("abort_release", int'(ack), 0);

        // Request while the chip is held in reset is refused
        tick();
        run_access(1'b0, 1'b1, 1, 2);
        resetl        = 1'b1;
        exp_ready_cyc = cyc + int'(L) + 3;
        tick();
        check("relock_not_ready", int'(ready), 0);
        wait_ready(64);
        tick();
        run_access(1'b1, 1'b0, 0, 1);

        // Controller reset while an ack is being held
        x.err     = 1'b0;
        x.rnw     = 1'b0;
        x.len     = int'(S);
        x.ack_cyc = cyc + int'(S) + 1;
        sb.push_back(x);
        req = 1'b1;
        rnw = 1'b0;
        wait_ack(64);
        tick();
        check("pre_rst_ack", int'(ack), 1);
        rst = 1'b1;
        req = 1'b0;
        tick();
        check_idle_pins("rst_mid_ack", 0);
        check("rst_mid_ack_ack", int'(ack), 0);
        check("rst_mid_ack_err", int'(err), 0);
        rst           = 1'b0;
        exp_ready_cyc = cyc + int'(L) + 3;
        wait_ready(64);
        tick();
        run_access(1'b0, 1'b0, 2, 1);

        check("scoreboard_empty", sb.size(), 0);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
